// File: rtl/bus_arb_mux.sv
// N-channel valid/ready arbiter feeding a single registered output stage.
// Channel choice is either direct (S) or round-robin starting after the last grant.
module bus_arb_mux #(
    parameter  int WIDTH = 8,
    parameter  int N     = 4,
    localparam int SW    = (N > 2) ? $clog2(N) : 1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [N*WIDTH-1:0] In,
    input  logic [N-1:0]       InValid,
    output logic [N-1:0]       InReady,
    input  logic               Mode,
    input  logic [SW-1:0]      S,
    output logic [WIDTH-1:0]   Out,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [SW-1:0]      OutSel
);

    logic [WIDTH-1:0] r_out;
    logic [SW-1:0]    r_out_sel;
    logic             r_out_valid;
    logic [SW-1:0]    r_ptr;

    logic             w_load;
    logic             w_grant_vld;
    logic [SW-1:0]    w_grant_idx;
    logic [WIDTH-1:0] w_grant_data;
    logic             w_xfer;

    // Output register can accept a word when empty or being drained this cycle.
    assign w_load = !r_out_valid || OutReady;

    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        if (Mode == 1'b0) begin
            if (int'(S) < N) begin
                w_grant_vld = InValid[S];
                w_grant_idx = S;
            end
        end else begin
            // Scan farthest-first so the nearest valid channel after r_ptr wins.
            for (int k = N; k >= 1; k--) begin
                if (InValid[(int'(r_ptr) + k) % N]) begin
                    w_grant_vld = 1'b1;
                    w_grant_idx = SW'((int'(r_ptr) + k) % N);
                end
            end
        end
    end

    always_comb begin
        w_grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant_idx == SW'(i)) begin
                w_grant_data = In[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_xfer = !Reset && w_load && w_grant_vld;

    always_comb begin
        InReady = '0;
        for (int i = 0; i < N; i++) begin
            InReady[i] = w_xfer && (w_grant_idx == SW'(i));
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_out       <= '0;
            r_out_sel   <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= SW'(N - 1);
        end else if (w_load) begin
            if (w_grant_vld) begin
                r_out       <= w_grant_data;
                r_out_sel   <= w_grant_idx;
                r_out_valid <= 1'b1;
                if (Mode) begin
                    r_ptr <= w_grant_idx;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign Out      = r_out;
    assign OutSel   = r_out_sel;
    assign OutValid = r_out_valid;

endmodule
